// File: rtl/sram_responder.sv
// On-chip emulation of the 16-bit async SRAM seen by the SoC. Pins are sampled
// once per clk; reads drive dq after READ_LATENCY edges, writes commit on trailing edge.
module sram_responder #(
  parameter int                  ADDR_WIDTH     = 18,
  parameter int                  DATA_WIDTH     = 16,
  parameter int                  MEM_ADDR_WIDTH = 12,
  parameter int                  READ_LATENCY   = 1,
  parameter logic [DATA_WIDTH-1:0] OOB_DATA     = 16'hDEAD
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  sram_ce_n,
  input  logic                  sram_oe_n,
  input  logic                  sram_we_n,
  input  logic [1:0]            sram_be_n,
  input  logic [ADDR_WIDTH-1:0] sram_addr,
  inout  wire  [DATA_WIDTH-1:0] sram_dq,
  output logic [15:0]           rd_count,
  output logic [15:0]           wr_count,
  output logic                  oob_err
);

  localparam int         NUM_LANES = 2;
  localparam int         DEPTH     = 1 << MEM_ADDR_WIDTH;
  localparam logic [2:0] LAT_M1    = 3'(READ_LATENCY - 1);

  typedef enum logic [1:0] {IDLE, RD_WAIT, RD_DRIVE, WR_HOLD} state_t;

  logic [NUM_LANES-1:0][7:0] mem [DEPTH];

  logic                  s_ce_n, s_oe_n, s_we_n;
  logic [1:0]            s_be_n;
  logic [ADDR_WIDTH-1:0] s_addr;
  logic [DATA_WIDTH-1:0] s_dq;

  state_t                    state, state_d;
  logic [2:0]                cnt, cnt_d;
  logic                      pend, pend_d;
  logic [ADDR_WIDTH-1:0]     tgt_addr, tgt_addr_d, drive_addr;
  logic [1:0]                tgt_be, tgt_be_d, drive_be;
  logic [DATA_WIDTH-1:0]     rdata, wr_data;
  logic [MEM_ADDR_WIDTH-1:0] wr_idx;
  logic [1:0]                wr_be;
  logic                      wr_oob;
  logic                      load, capture, commit, inc_rd;

  wire wr_req   = !s_ce_n && !s_we_n;
  wire rd_req   = !s_ce_n && s_we_n && !s_oe_n;
  wire s_oob    = |s_addr[ADDR_WIDTH-1:MEM_ADDR_WIDTH];
  // Sampled we_n low always wins the bus back, even before the FSM leaves RD_DRIVE.
  wire drive_on = (state == RD_DRIVE) && s_we_n;

  for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
    assign sram_dq[i*8 +: 8] = (drive_on && !drive_be[i]) ? rdata[i*8 +: 8] : 8'hzz;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s_ce_n <= 1'b1;
      s_oe_n <= 1'b1;
      s_we_n <= 1'b1;
      s_be_n <= 2'b11;
      s_addr <= '0;
      s_dq   <= '0;
    end else begin
      s_ce_n <= sram_ce_n;
      s_oe_n <= sram_oe_n;
      s_we_n <= sram_we_n;
      s_be_n <= sram_be_n;
      s_addr <= sram_addr;
      s_dq   <= sram_dq;
    end
  end

  always_comb begin
    state_d    = state;
    cnt_d      = cnt;
    pend_d     = pend;
    tgt_addr_d = tgt_addr;
    tgt_be_d   = tgt_be;
    load       = 1'b0;
    capture    = 1'b0;
    commit     = 1'b0;
    case (state)
      IDLE: begin
        if (wr_req) begin
          state_d = WR_HOLD;
          capture = 1'b1;
        end else if (rd_req) begin
          if (READ_LATENCY == 1) begin
            state_d = RD_DRIVE;
            load    = 1'b1;
          end else begin
            state_d    = RD_WAIT;
            cnt_d      = LAT_M1;
            tgt_addr_d = s_addr;
          end
        end
      end
      RD_WAIT: begin
        if (wr_req) begin
          state_d = WR_HOLD;
          capture = 1'b1;
        end else if (!rd_req) begin
          state_d = IDLE;
        end else if (s_addr != tgt_addr) begin
          cnt_d      = LAT_M1;
          tgt_addr_d = s_addr;
        end else if (cnt <= 3'd1) begin
          state_d = RD_DRIVE;
          load    = 1'b1;
        end else begin
          cnt_d = cnt - 3'd1;
        end
      end
      RD_DRIVE: begin
        if (wr_req) begin
          state_d = WR_HOLD;
          capture = 1'b1;
          pend_d  = 1'b0;
        end else if (!rd_req) begin
          state_d = IDLE;
          pend_d  = 1'b0;
        end else if ({s_addr, s_be_n} != {tgt_addr, tgt_be}) begin
          // New target: old data stays on the bus until the latency expires.
          tgt_addr_d = s_addr;
          tgt_be_d   = s_be_n;
          if (READ_LATENCY == 1) load = 1'b1;
          else begin
            pend_d = 1'b1;
            cnt_d  = LAT_M1;
          end
        end else if (pend) begin
          if (cnt <= 3'd1) begin
            load   = 1'b1;
            pend_d = 1'b0;
          end else begin
            cnt_d = cnt - 3'd1;
          end
        end
      end
      WR_HOLD: begin
        if (wr_req) begin
          capture = 1'b1;
        end else begin
          commit = 1'b1;
          if (rd_req) begin
            state_d    = RD_WAIT;
            cnt_d      = LAT_M1;
            tgt_addr_d = s_addr;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
    if (load) begin
      tgt_addr_d = s_addr;
      tgt_be_d   = s_be_n;
    end
    inc_rd = load && ((state != RD_DRIVE) || (s_addr != drive_addr));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      cnt        <= '0;
      pend       <= 1'b0;
      tgt_addr   <= '0;
      tgt_be     <= 2'b11;
      drive_addr <= '0;
      drive_be   <= 2'b11;
      rdata      <= '0;
      wr_idx     <= '0;
      wr_be      <= 2'b11;
      wr_data    <= '0;
      wr_oob     <= 1'b0;
      rd_count   <= '0;
      wr_count   <= '0;
      oob_err    <= 1'b0;
    end else begin
      state    <= state_d;
      cnt      <= cnt_d;
      pend     <= pend_d;
      tgt_addr <= tgt_addr_d;
      tgt_be   <= tgt_be_d;
      if (load) begin
        rdata      <= s_oob ? OOB_DATA : mem[s_addr[MEM_ADDR_WIDTH-1:0]];
        drive_addr <= s_addr;
        drive_be   <= s_be_n;
      end
      if (capture) begin
        wr_idx  <= s_addr[MEM_ADDR_WIDTH-1:0];
        wr_be   <= s_be_n;
        wr_data <= s_dq;
        wr_oob  <= s_oob;
      end
      if (inc_rd) rd_count <= rd_count + 16'd1;
      if (commit && !wr_oob) wr_count <= wr_count + 16'd1;
      if ((load && s_oob) || (commit && wr_oob)) oob_err <= 1'b1;
    end
  end

  // RAM has no reset so contents survive rst_n.
  always_ff @(posedge clk) begin
    if (commit && !wr_oob) begin
      for (int i = 0; i < NUM_LANES; i++)
        if (!wr_be[i]) mem[wr_idx][i] <= wr_data[i*8 +: 8];
    end
  end

endmodule

// File: tb/tb_sram_responder.sv
// Directed bench for sram_responder: two instances (latency 2 and 3) share the
// SoC-side pins; each has its own pulled-up dq bus so a released lane reads 8'hFF.
module tb_sram_responder;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        ce_n, oe_n, we_n;
  logic [1:0]  be_n;
  logic [17:0] addr;
  logic        drv_en;
  logic [15:0] drv_data;
  wire  [15:0] dq2, dq3;
  logic [15:0] rd2, wr2, rd3, wr3;
  logic        oob2, oob3;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  assign dq2 = drv_en ? drv_data : 16'hzzzz;
  assign dq3 = drv_en ? drv_data : 16'hzzzz;
  for (genvar i = 0; i < 16; i++) begin : g_pu
    pullup (dq2[i]);
    pullup (dq3[i]);
  end

  sram_responder #(.READ_LATENCY(2)) u2 (
    .clk(clk), .rst_n(rst_n), .sram_ce_n(ce_n), .sram_oe_n(oe_n), .sram_we_n(we_n),
    .sram_be_n(be_n), .sram_addr(addr), .sram_dq(dq2),
    .rd_count(rd2), .wr_count(wr2), .oob_err(oob2));

  sram_responder #(.READ_LATENCY(3)) u3 (
    .clk(clk), .rst_n(rst_n), .sram_ce_n(ce_n), .sram_oe_n(oe_n), .sram_we_n(we_n),
    .sram_be_n(be_n), .sram_addr(addr), .sram_dq(dq3),
    .rd_count(rd3), .wr_count(wr3), .oob_err(oob3));

  // k: 0 idle, 1 write, 2 read, 3 write with oe_n also low
  typedef struct {
    int          k;
    logic [17:0] a;
    logic [1:0]  be;
    logic [15:0] d;
    logic [15:0] exp_dq;
    logic [15:0] exp_rd;
    logic [15:0] exp_wr;
    logic        exp_oob;
  } vec_t;

  function automatic vec_t mk(int k, logic [17:0] a, logic [1:0] be, logic [15:0] d,
                              logic [15:0] edq, logic [15:0] erd, logic [15:0] ewr, logic eoob);
    vec_t v;
    v.k = k; v.a = a; v.be = be; v.d = d;
    v.exp_dq = edq; v.exp_rd = erd; v.exp_wr = ewr; v.exp_oob = eoob;
    return v;
  endfunction

  task automatic drive(int k, logic [17:0] a, logic [1:0] be, logic [15:0] d);
    ce_n     = (k == 0);
    we_n     = !(k == 1 || k == 3);
    oe_n     = !(k == 2 || k == 3);
    be_n     = be;
    addr     = a;
    drv_en   = (k == 1 || k == 3);
    drv_data = d;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  vec_t tbl[39];

  initial begin
    // write 1234@5, read (lat 2), UB-only read, byte-lane write, write+oe, oob
    tbl[0]  = mk(0, 18'h0,    2'b11, 16'h0,    16'hFFFF, 0, 0, 0);
    tbl[1]  = mk(1, 18'h5,    2'b00, 16'h1234, 16'h1234, 0, 0, 0);
    tbl[2]  = mk(0, 18'h0,    2'b11, 16'h0,    16'hFFFF, 0, 0, 0);
    tbl[3]  = mk(2, 18'h5,    2'b00, 16'h0,    16'hFFFF, 0, 1, 0);
    tbl[4]  = mk(2, 18'h5,    2'b00, 16'h0,    16'hFFFF, 0, 1, 0);
    tbl[5]  = mk(2, 18'h5,    2'b00, 16'h0,    16'h1234, 1, 1, 0);
    tbl[6]  = mk(2, 18'h5,    2'b01, 16'h0,    16'h1234, 1, 1, 0);
    tbl[7]  = mk(2, 18'h5,    2'b01, 16'h0,    16'h1234, 1, 1, 0);
    tbl[8]  = mk(2, 18'h5,    2'b01, 16'h0,    16'h12FF, 1, 1, 0);
    tbl[9]  = mk(0, 18'h0,    2'b11, 16'h0,    16'h12FF, 1, 1, 0);
    tbl[10] = mk(0, 18'h0,    2'b11, 16'h0,    16'hFFFF, 1, 1, 0);
    tbl[11] = mk(1, 18'h5,    2'b10, 16'hABCD, 16'hABCD, 1, 1, 0);
    tbl[12] = mk(0, 18'h0,    2'b11, 16'h0,    16'hFFFF, 1, 1, 0);
    tbl[13] = mk(0, 18'h0,    2'b11, 16'h0,    16'hFFFF, 1, 2, 0);
    tbl[14] = mk(2, 18'h5,    2'b00, 16'h0,    16'hFFFF, 1, 2, 0);
    tbl[15] = mk(2, 18'h5,    2'b00, 16'h0,    16'hFFFF, 1, 2, 0);
    tbl[16] = mk(2, 18'h5,    2'b00, 16'h0,    16'h12CD, 2, 2, 0);
    tbl[17] = mk(0, 18'h0,    2'b11, 16'h0,    16'h12CD, 2, 2, 0);
    tbl[18] = mk(0, 18'h0,    2'b11, 16'h0,    16'hFFFF, 2, 2, 0);
    tbl[19] = mk(3, 18'h0,    2'b00, 16'h1111, 16'h1111, 2, 2, 0);
    tbl[20] = mk(3, 18'h0,    2'b00, 16'h2222, 16'h2222, 2, 2, 0);
    tbl[21] = mk(3, 18'h0,    2'b00, 16'h3333, 16'h3333, 2, 2, 0);
    tbl[22] = mk(3, 18'h0,    2'b00, 16'h0F0F, 16'h0F0F, 2, 2, 0);
    tbl[23] = mk(2, 18'h0,    2'b00, 16'h0,    16'hFFFF, 2, 2, 0);
    tbl[24] = mk(2, 18'h0,    2'b00, 16'h0,    16'hFFFF, 2, 3, 0);
    tbl[25] = mk(2, 18'h0,    2'b00, 16'h0,    16'h0F0F, 3, 3, 0);
    tbl[26] = mk(0, 18'h0,    2'b11, 16'h0,    16'h0F0F, 3, 3, 0);
    tbl[27] = mk(0, 18'h0,    2'b11, 16'h0,    16'hFFFF, 3, 3, 0);
    tbl[28] = mk(2, 18'h1000, 2'b00, 16'h0,    16'hFFFF, 3, 3, 0);
    tbl[29] = mk(2, 18'h1000, 2'b00, 16'h0,    16'hFFFF, 3, 3, 0);
    tbl[30] = mk(2, 18'h1000, 2'b00, 16'h0,    16'hDEAD, 4, 3, 1);
    tbl[31] = mk(1, 18'h1000, 2'b00, 16'h5555, 16'h5555, 4, 3, 1);
    tbl[32] = mk(0, 18'h0,    2'b11, 16'h0,    16'hFFFF, 4, 3, 1);
    tbl[33] = mk(0, 18'h0,    2'b11, 16'h0,    16'hFFFF, 4, 3, 1);
    tbl[34] = mk(2, 18'h0,    2'b00, 16'h0,    16'hFFFF, 4, 3, 1);
    tbl[35] = mk(2, 18'h0,    2'b00, 16'h0,    16'hFFFF, 4, 3, 1);
    tbl[36] = mk(2, 18'h0,    2'b00, 16'h0,    16'h0F0F, 5, 3, 1);
    tbl[37] = mk(0, 18'h0,    2'b11, 16'h0,    16'h0F0F, 5, 3, 1);
    tbl[38] = mk(0, 18'h0,    2'b11, 16'h0,    16'hFFFF, 5, 3, 1);

    rst_n = 1'b0;
    drive(0, 18'h0, 2'b11, 16'h0);
    tick(); tick();
    chk("reset dq", dq2, 16'hFFFF);
    chk("reset rd_count", rd2, 16'h0);
    chk("reset wr_count", wr2, 16'h0);
    chk("reset oob_err", oob2, 1'b0);
    rst_n = 1'b1;

    for (int i = 0; i < 39; i++) begin
      drive(tbl[i].k, tbl[i].a, tbl[i].be, tbl[i].d);
      tick();
      chk($sformatf("row%0d dq", i), dq2, tbl[i].exp_dq);
      chk($sformatf("row%0d rd_count", i), rd2, tbl[i].exp_rd);
      chk($sformatf("row%0d wr_count", i), wr2, tbl[i].exp_wr);
      chk($sformatf("row%0d oob_err", i), oob2, tbl[i].exp_oob);
    end

    // reset during WR_HOLD: pending write discarded, RAM retained
    drive(1, 18'h7, 2'b00, 16'h1357); tick();
    drive(0, 18'h0, 2'b11, 16'h0); tick(); tick();
    chk("pre-reset wr_count", wr2, 16'd4);
    drive(1, 18'h7, 2'b00, 16'h9BDF); tick(); tick();
    drive(0, 18'h0, 2'b11, 16'h0);
    #2 rst_n = 1'b0;
    #1;
    chk("async reset dq", dq2, 16'hFFFF);
    chk("async reset rd_count", rd2, 16'h0);
    chk("async reset wr_count", wr2, 16'h0);
    chk("async reset oob_err", oob2, 1'b0);
    tick(); tick();
    rst_n = 1'b1;
    drive(2, 18'h7, 2'b00, 16'h0);
    tick(); chk("rd7 N dq", dq2, 16'hFFFF);
    tick(); chk("rd7 N+1 dq", dq2, 16'hFFFF);
    tick(); chk("rd7 N+2 dq", dq2, 16'h1357);
    chk("rd7 rd_count", rd2, 16'd1);
    chk("rd7 wr_count", wr2, 16'd0);
    drive(2, 18'h5, 2'b00, 16'h0);
    tick(); chk("switch C dq", dq2, 16'h1357);
    tick(); chk("switch C+1 dq", dq2, 16'h1357);
    tick(); chk("switch C+2 dq", dq2, 16'h12CD);
    chk("switch rd_count", rd2, 16'd2);
    drive(0, 18'h0, 2'b11, 16'h0);
    tick(); chk("release hold dq", dq2, 16'h12CD);
    tick(); chk("release dq", dq2, 16'hFFFF);

    // latency-3 instance: address switch mid RD_DRIVE
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    drive(1, 18'h3, 2'b00, 16'hA3A3); tick();
    drive(0, 18'h0, 2'b11, 16'h0); tick(); tick();
    drive(1, 18'h4, 2'b00, 16'hB4B4); tick();
    drive(0, 18'h0, 2'b11, 16'h0); tick(); tick();
    chk("lat3 wr_count", wr3, 16'd2);
    drive(2, 18'h3, 2'b00, 16'h0);
    tick(); chk("lat3 N dq", dq3, 16'hFFFF);
    tick(); chk("lat3 N+1 dq", dq3, 16'hFFFF);
    tick(); chk("lat3 N+2 dq", dq3, 16'hFFFF);
    tick(); chk("lat3 N+3 dq", dq3, 16'hA3A3);
    chk("lat3 rd_count 1", rd3, 16'd1);
    drive(2, 18'h4, 2'b00, 16'h0);
    tick(); chk("lat3 C dq", dq3, 16'hA3A3);
    tick(); chk("lat3 C+1 dq", dq3, 16'hA3A3);
    tick(); chk("lat3 C+2 dq", dq3, 16'hA3A3);
    tick(); chk("lat3 C+3 dq", dq3, 16'hB4B4);
    chk("lat3 rd_count 2", rd3, 16'd2);
    chk("lat3 oob_err", oob3, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    chk("reset while driving dq", dq3, 16'hFFFF);
    chk("reset while driving rd_count", rd3, 16'h0);
    rst_n = 1'b1;
    drive(0, 18'h0, 2'b11, 16'h0);
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
